// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready flow control,
// stall, synchronous flush, NOP bubble insertion and an optional 2-entry skid.
//   clock/reset_n         : rising-edge clock, asynchronous active-low reset
//   flush                 : squash every held entry and any input offered this cycle
//   in_valid/in_ready     : upstream handshake, in_ctrl/in_data carried with it
//   out_valid/out_ready   : downstream handshake, out_ctrl/out_data presented
//   count                 : number of entries currently held
module pipe_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 128,
    parameter int SKID   = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_out_xfer = r_valid && out_ready;
    assign out_valid  = r_valid;
    // an empty stage presents a NOP; data is left stale on purpose
    assign out_ctrl   = r_valid ? r_ctrl : '0;
    assign out_data   = r_data;

    generate
        if (SKID == 0) begin : g_single
            assign in_ready  = !r_valid || out_ready;
            assign w_in_xfer = in_valid && in_ready;
            assign count     = {1'b0, r_valid};
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                    r_ctrl  <= in_ctrl;
                    r_data  <= in_data;
                end else if (w_out_xfer) begin
                    r_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            state_t            r_state;
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            // in_ready comes from a flop so out_ready never reaches it combinationally
            assign in_ready  = r_in_ready;
            assign w_in_xfer = in_valid && r_in_ready;
            assign count     = r_state;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_state     <= EMPTY;
                    r_valid     <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_ctrl      <= '0;
                    r_data      <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (flush) begin
                    r_state    <= EMPTY;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: if (w_in_xfer) begin
                            r_ctrl  <= in_ctrl;
                            r_data  <= in_data;
                            r_valid <= 1'b1;
                            r_state <= ONE;
                        end
                        ONE: if (w_in_xfer && w_out_xfer) begin
                            r_ctrl <= in_ctrl;
                            r_data <= in_data;
                        end else if (w_in_xfer) begin
                            // main is stalled: park the newcomer behind it
                            r_skid_ctrl <= in_ctrl;
                            r_skid_data <= in_data;
                            r_state     <= TWO;
                            r_in_ready  <= 1'b0;
                        end else if (w_out_xfer) begin
                            r_valid <= 1'b0;
                            r_state <= EMPTY;
                        end
                        TWO: if (w_out_xfer) begin
                            r_ctrl     <= r_skid_ctrl;
                            r_data     <= r_skid_data;
                            r_state    <= ONE;
                            r_in_ready <= 1'b1;
                        end
                        default: begin
                            r_state    <= EMPTY;
                            r_valid    <= 1'b0;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives SKID=0 and SKID=1 instances with the same stimulus and
// compares each against a queue-based FIFO reference model.
module tb_pipe_stage_reg;
    localparam int CW = 12;
    localparam int DW = 128;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    count0, count1;

    ent_t          q0[$];
    ent_t          q1[$];
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .count(count0)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .count(count1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("s0_valid", DW'(out_valid0), DW'(q0.size() != 0));
        chk("s0_ctrl", DW'(out_ctrl0), q0.size() != 0 ? DW'(q0[0].c) : '0);
        chk("s0_data", out_data0, q0.size() != 0 ? q0[0].d : last0);
        chk("s0_count", DW'(count0), DW'(q0.size()));
        chk("s0_ready", DW'(in_ready0), DW'(q0.size() == 0 || out_ready));
        chk("s1_valid", DW'(out_valid1), DW'(q1.size() != 0));
        chk("s1_ctrl", DW'(out_ctrl1), q1.size() != 0 ? DW'(q1[0].c) : '0);
        chk("s1_data", out_data1, q1.size() != 0 ? q1[0].d : last1);
        chk("s1_count", DW'(count1), DW'(q1.size()));
        chk("s1_ready", DW'(in_ready1), DW'(q1.size() < 2));
    endtask

    task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic orr, input logic fl);
        bit a0, a1, p0, p1;
        @(negedge clock);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = orr;
        flush     = fl;
        #1 check_all();
        out_ready = !orr;
        #1 chk("s1_ready_path", DW'(in_ready1), DW'(q1.size() < 2));
        out_ready = orr;
        a0 = iv && (q0.size() == 0 || orr);
        p0 = q0.size() != 0 && orr;
        a1 = iv && q1.size() < 2;
        p1 = q1.size() != 0 && orr;
        if (q0.size() != 0) last0 = q0[0].d;
        if (q1.size() != 0) last1 = q1[0].d;
        @(posedge clock);
        if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (a0) q0.push_back({ic, id});
            if (p1) void'(q1.pop_front());
            if (a1) q1.push_back({ic, id});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        #1 check_all();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 12'h001, 128'hA, 1'b0, 1'b0);
        step(1'b1, 12'h002, 128'hB, 1'b0, 1'b0);
        repeat (2) step(1'b1, 12'h003, 128'hC, 1'b0, 1'b0);
        repeat (2) step(1'b1, 12'h003, 128'hC, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 12'h001, 128'hA, 1'b0, 1'b0);
        step(1'b1, 12'h002, 128'hB, 1'b0, 1'b0);
        step(1'b1, 12'h004, 128'hD, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 12'hFFF, 128'h55, 1'b1, 1'b0);
        repeat (3) step(1'b0, 12'hFFF, 128'h55, 1'b0, 1'b0);
        step(1'b1, 12'h001, 128'hA, 1'b0, 1'b0);
        step(1'b1, 12'h002, 128'hB, 1'b0, 1'b0);
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            step($urandom_range(0, 3) != 0, CW'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the processor pipeline, replacing the fixed-field IF/ID and ID/EX buffers with one reusable block. It carries a control bundle and a data bundle between stages and adds valid/ready flow control, stall, synchronous flush and bubble insertion. An optional two-entry skid mode breaks the combinational ready path between stages.

## Interface
Parameters:
- CTRL_W, 12, width of control bundle (aluOp, memRead, memWrite, regWrt, branch/jump bits); all-zero encodes a NOP.
- DATA_W, 128, width of data bundle (pc, pc+y, xrs, xrt, y, ...).
- SKID, 0, 0 = single-entry register; 1 = two-entry skid buffer.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries (branch/jump taken).
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  block can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream has a valid instruction.
- out_ready  in  1  downstream consumes this cycle (low = stall).
- out_ctrl  out  CTRL_W  control to next stage; forced 0 when out_valid=0.
- out_data  out  DATA_W  data to next stage.
- count  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- SKID=0: one register. in_ready = !out_valid || out_ready (combinational). On an input transfer the register loads in_ctrl/in_data and out_valid=1; on an output transfer without an input transfer out_valid=0.
- SKID=1: main register (drives outputs) plus skid register. States EMPTY (count 0), ONE (1), TWO (2).
  - EMPTY: input transfer -> main loads, ONE.
  - ONE: in only -> skid loads, TWO; out only -> EMPTY; in and out -> main loads new, stays ONE.
  - TWO: in_ready=0; out transfer -> skid moves to main, ONE.
  - in_ready is a registered signal, equal to (state != TWO); no combinational path from out_ready to in_ready.
- Ordering strictly FIFO; no entry is dropped or duplicated except by flush.
- Bubble: whenever out_valid=0, out_ctrl=0 so downstream sees a NOP; out_data holds its last value.
- flush: highest priority. At the edge, all entries discard, count=0, out_valid=0, state EMPTY; any input offered in the flush cycle is dropped even if in_ready was high. in_ready=1 in the following cycle.
- reset_n low (any time, mid-transfer included): out_valid=0, out_ctrl=0, out_data=0, count=0, in_ready=1 (SKID=1 register value; SKID=0 follows formula), state EMPTY. Skid register contents cleared to 0.

## Timing
- Latency: input accepted at edge N is on out_* after edge N (visible in cycle N+1) when the block was empty or draining; in SKID=1, an entry parked in skid appears one cycle after the main entry leaves.
- Throughput: one transfer per cycle in both modes while out_ready=1.
- SKID=0: in_ready combinational from out_ready and out_valid; out_* registered.
- SKID=1: all outputs registered, including in_ready.
- Simultaneous flush with in/out transfers: output transfer at that edge still counts as consumed by downstream; block ends empty.
- out_ready toggling while out_valid=0 has no effect.

## Test plan
- Reset: assert reset_n=0 mid-stream with count=2 (SKID=1) -> immediately out_valid=0, out_ctrl=0, count=0; after release in_ready=1.
- Streaming: SKID=0 and SKID=1, out_ready=1, inputs data 0x1..0x8 every cycle -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, count stays 1.
- Stall: SKID=1, out_ready=0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, count=2, in_ready=0, 0xC held upstream; raise out_ready -> 0xA, 0xB, 0xC emerge consecutively.
- Flush: SKID=1 holding 0xA, 0xB, flush=1 with in_valid=1 data 0xD -> next cycle out_valid=0, out_ctrl=0, count=0, 0xD never appears; in_ready=1.
- Bubble: SKID=0, in_valid=0 for 3 cycles with in_ctrl=0xFFF -> out_valid=0, out_ctrl=0x000 throughout.
- Ready path: SKID=1, toggle out_ready combinationally within a cycle -> in_ready changes only at clock edges.
